imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch-stage controller that owns the single port of the instruction memory. It sequences the program counter for the pipeline, applying stall, branch-redirect and halt. It also arbitrates the memory between the fetch path and a program-loader port that writes instruction words before execution. It sits between the hazard/branch logic (ID/EX) and the instruction memory array.

Parameters:
ADDR_W, 10, instruction-memory word-address width (1024 words)
RESET_PC, 32'h0000_0000, byte address fetched first after START

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: leave IDLE/HALT and begin fetching at RESET_PC
halt_req  in  1  level: stop fetching after the current cycle
stall  in  1  hazard stall from the hazard-detection unit; hold PC
br_taken  in  1  branch/jump resolved taken this cycle
br_target  in  32  byte target address
ld_req  in  1  loader requests ownership of the memory
ld_valid  in  1  loader write beat valid
ld_addr  in  ADDR_W  word address of the beat
ld_data  in  32  instruction word to write
ld_done  in  1  loader finished; release the memory
ld_gnt  out  1  loader owns the memory (state LOAD)
imem_addr  out  ADDR_W  word address to the memory
imem_we  out  1  write enable to the memory
imem_wdata  out  32  write data to the memory
pc  out  32  byte PC of the instruction being fetched
if_valid  out  1  fetched word is a real instruction, not a bubble
misalign  out  1  sticky: a taken target had br_target[1:0] != 0
state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC[ADDR_W+1:2], imem_we=0, imem_wdata=0, ld_gnt=0, if_valid=0, misalign=0.
- imem_addr is pc[ADDR_W+1:2] in RUN/IDLE/HALT. It is ld_addr in LOAD. All outputs are registered.
- IDLE: ld_req -> LOAD. Otherwise start -> RUN with pc=RESET_PC. If both arrive in the same cycle, ld_req wins.
- LOAD: ld_gnt=1. Each cycle with ld_valid=1 drives imem_we=1, imem_wdata=ld_data and imem_addr=ld_addr on the next edge, giving one-cycle write latency and one beat per cycle with no backpressure. ld_done -> IDLE. A ld_valid in the same cycle as ld_done is still written. start is ignored in LOAD.
- RUN: if_valid=1 except on the cycle after a redirect. The PC update priority per edge is:
  1. halt_req: go to HALT; pc holds.
  2. br_taken: pc={br_target[31:2],2'b00}. The next cycle has if_valid=0 (one-bubble flush). If br_target[1:0]!=0, set misalign.
  3. stall: pc holds and if_valid holds.
  4. Otherwise pc=pc+4.
- br_taken together with stall: the redirect wins, because a flush overrides a stall.
- ld_req in RUN is ignored; the loader must wait for IDLE/HALT.
- Wrap-around: pc is a full 32-bit value and wraps at 2^32. imem_addr wraps modulo 2^ADDR_W, so pc 0x0000_0FFC+4 gives imem_addr 0.
- HALT: if_valid=0 and pc holds. start -> RUN at RESET_PC. ld_req -> LOAD. If both arrive together, ld_req wins.
- misalign clears only on reset.
- imem_we is never asserted outside LOAD.

Optional Feature:
IMEM_FETCH_PERF_EN.
- When defined: adds 32-bit output ports perf_fetch, perf_stall and perf_flush. They count RUN cycles with if_valid=1, stall cycles in RUN, and taken redirects. The counters saturate at all-ones, reset to 0, and clear on start.
- When undefined: these ports and their counters do not exist.

Decomposition:
- Package imem_fetch_pkg: the state encoding constants (IDLE, LOAD, RUN, HALT), the PC increment constant 4, and the RESET_PC default.
- Sub-module imem_pc_next: the combinational next-PC and priority mux (halt > branch > stall > increment), plus misalign detection. The FSM and loader mux stay in the top module.

Test Plan:
- Reset, then load: ld_req; beats {0:0x01095820, 1:0xAC0B0000, 2:0x01696022}; ld_done -> three writes with imem_we=1 at addresses 0,1,2; state returns to IDLE; ld_gnt drops.
- start, free-run 5 cycles -> pc 0,4,8,12,16; if_valid=1 throughout; imem_addr 0..4.
- stall held 2 cycles at pc=8 -> pc stays 8 for 2 cycles, then 12.
- br_taken=1, stall=1, br_target=0x4 at pc=0xC -> pc=0x4; one if_valid=0 bubble; misalign=0. Then br_target=0x6 -> pc=0x4 and misalign=1.
- pc=0xFFC with ADDR_W=10 -> next pc=0x1000 and imem_addr=0. Then halt_req -> HALT, pc frozen. ld_req during RUN is ignored until HALT.
- rst_n low mid-LOAD, with ld_valid=1 -> imem_we=0 and state=IDLE immediately; no write lands after the reset edge.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Optional perf counters are enabled with IMEM_FETCH_PERF_EN.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Pipeline control, loader and memory-port bundle of the fetch controller.
// IMEM_FETCH_PERF_EN adds the perf counter outputs.
interface imem_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              halt_req;
    logic              stall;
    logic              br_taken;
    logic [31:0]       br_target;
    logic              ld_req;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              ld_gnt;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic [31:0]       pc;
    logic              if_valid;
    logic              misalign;
    logic [1:0]        state;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_stall;
    logic [31:0]       perf_flush;

    modport master (
        output start, halt_req, stall, br_taken, br_target,
        output ld_req, ld_valid, ld_addr, ld_data, ld_done,
        input  ld_gnt, imem_addr, imem_we, imem_wdata,
        input  pc, if_valid, misalign, state,
        input  perf_fetch, perf_stall, perf_flush
    );
    modport slave (
        input  start, halt_req, stall, br_taken, br_target,
        input  ld_req, ld_valid, ld_addr, ld_data, ld_done,
        output ld_gnt, imem_addr, imem_we, imem_wdata,
        output pc, if_valid, misalign, state,
        output perf_fetch, perf_stall, perf_flush
    );
`else
    modport master (
        output start, halt_req, stall, br_taken, br_target,
        output ld_req, ld_valid, ld_addr, ld_data, ld_done,
        input  ld_gnt, imem_addr, imem_we, imem_wdata,
        input  pc, if_valid, misalign, state
    );
    modport slave (
        input  start, halt_req, stall, br_taken, br_target,
        input  ld_req, ld_valid, ld_addr, ld_data, ld_done,
        output ld_gnt, imem_addr, imem_we, imem_wdata,
        output pc, if_valid, misalign, state
    );
`endif
endinterface

// File: rtl/imem_pc_next.sv
// Next-PC priority mux for the RUN state: halt > branch > stall > increment.
module imem_pc_next
    import imem_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        vld_i,
    input  logic        halt_i,
    input  logic        br_i,
    input  logic [31:0] tgt_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic        vld_o,
    output logic        misal_o
);

    // Overlapping requests are legal, so this is a priority chain.
    always_comb begin
        pc_o    = pc_i;
        vld_o   = vld_i;
        misal_o = 1'b0;
        if (halt_i) begin
            vld_o = 1'b0;
        end else if (br_i) begin
            pc_o    = {tgt_i[31:2], 2'b00};
            vld_o   = 1'b0;
            misal_o = |tgt_i[1:0];
        end else if (!stall_i) begin
            pc_o  = pc_i + PC_INC;
            vld_o = 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: PC sequencing plus loader/fetch arbitration of the imem.
// IMEM_FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input logic         clk,
    input logic         rst_n,
    imem_fetch_if.slave bus
);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              vld_q, vld_d;
    logic              mis_q, mis_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              gnt_q, gnt_d;
    logic [31:0]       nx_pc;
    logic              nx_vld;
    logic              nx_mis;
    logic              go;

    imem_pc_next u_pc_next (
        .pc_i    (pc_q),
        .vld_i   (vld_q),
        .halt_i  (bus.halt_req),
        .br_i    (bus.br_taken),
        .tgt_i   (bus.br_target),
        .stall_i (bus.stall),
        .pc_o    (nx_pc),
        .vld_o   (nx_vld),
        .misal_o (nx_mis)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        mis_d   = mis_q;
        we_d    = 1'b0;
        wdata_d = '0;
        go      = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                vld_d = 1'b0;
                if (bus.ld_req) begin
                    state_d = S_LOAD;
                end else if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    vld_d   = 1'b1;
                    go      = 1'b1;
                end
            end
            S_LOAD: begin
                vld_d = 1'b0;
                if (bus.ld_valid) begin
                    we_d    = 1'b1;
                    wdata_d = bus.ld_data;
                end
                if (bus.ld_done) state_d = S_IDLE;
            end
            S_RUN: begin
                pc_d  = nx_pc;
                vld_d = nx_vld;
                mis_d = mis_q | nx_mis;
                if (bus.halt_req) state_d = S_HALT;
            end
            default: ;
        endcase
        // A final beat alongside ld_done still owns the address bus.
        if (we_d || state_d == S_LOAD)
            addr_d = bus.ld_addr;
        else
            addr_d = pc_d[ADDR_W+1:2];
        gnt_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= RESET_PC[ADDR_W+1:2];
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            mis_q   <= mis_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.pc         = pc_q;
    assign bus.if_valid   = vld_q;
    assign bus.misalign   = mis_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.imem_addr  = addr_q;
    assign bus.ld_gnt     = gnt_q;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] pf_q, ps_q, pr_q;
    logic        in_run;

    assign in_run = (state_q == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_q <= '0;
            ps_q <= '0;
            pr_q <= '0;
        end else if (go) begin
            pf_q <= '0;
            ps_q <= '0;
            pr_q <= '0;
        end else begin
            if (in_run && vld_q)
                pf_q <= sat_inc(pf_q);
            if (in_run && bus.stall && !bus.halt_req && !bus.br_taken)
                ps_q <= sat_inc(ps_q);
            if (in_run && bus.br_taken && !bus.halt_req)
                pr_q <= sat_inc(pr_q);
        end
    end

    assign bus.perf_fetch = pf_q;
    assign bus.perf_stall = ps_q;
    assign bus.perf_flush = pr_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed plus random stimulus against a cycle-level reference model
// of the fetch controller.
module tb_imem_fetch_ctrl;

    localparam int          AW   = 10;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state: mode 0=idle 1=load 2=run 3=halt
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_vld, m_mis, m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_addr;

    always #5 clk = ~clk;

    imem_fetch_if #(.ADDR_W(AW)) bus ();

    imem_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_in();
        bus.start     = 0;
        bus.halt_req  = 0;
        bus.stall     = 0;
        bus.br_taken  = 0;
        bus.br_target = '0;
        bus.ld_req    = 0;
        bus.ld_valid  = 0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_done   = 0;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = RPC;
        m_vld   = 0;
        m_mis   = 0;
        m_we    = 0;
        m_wdata = 0;
        m_addr  = (RPC / 4) % (1 << AW);
    endtask

    task automatic model_step();
        int prev = m_mode;
        m_we = 0;
        if (prev == 0 || prev == 3) begin
            m_vld = 0;
            if (bus.ld_req) m_mode = 1;
            else if (bus.start) begin
                m_mode = 2;
                m_pc   = RPC;
                m_vld  = 1;
            end
        end else if (prev == 1) begin
            if (bus.ld_valid) begin
                m_we    = 1;
                m_wdata = bus.ld_data;
            end
            if (bus.ld_done) m_mode = 0;
        end else begin
            if (bus.halt_req) begin
                m_mode = 3;
                m_vld  = 0;
            end else if (bus.br_taken) begin
                m_pc  = bus.br_target - (bus.br_target % 4);
                m_vld = 0;
                if (bus.br_target % 4 != 0) m_mis = 1;
            end else if (!bus.stall) begin
                m_pc  = m_pc + 4;
                m_vld = 1;
            end
        end
        if (m_we || m_mode == 1) m_addr = bus.ld_addr;
        else m_addr = (m_pc / 4) % (1 << AW);
    endtask

    task automatic compare();
        chk("state", bus.state, m_mode);
        chk("pc", bus.pc, m_pc);
        chk("if_valid", bus.if_valid, m_vld);
        chk("misalign", bus.misalign, m_mis);
        chk("ld_gnt", bus.ld_gnt, m_mode == 1);
        chk("imem_we", bus.imem_we, m_we);
        chk("imem_addr", bus.imem_addr, m_addr);
        if (m_we) chk("imem_wdata", bus.imem_wdata, m_wdata);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        compare();
        chk("rst_wdata", bus.imem_wdata, 0);
        @(posedge clk);
        #1;
        compare();
        rst_n = 1;
    endtask

    task automatic beat(input int a, input logic [31:0] d, input bit done);
        clr_in();
        bus.ld_valid = 1;
        bus.ld_addr  = a[AW-1:0];
        bus.ld_data  = d;
        bus.ld_done  = done;
        cyc();
    endtask

    task automatic br(input logic [31:0] t, input bit st);
        clr_in();
        bus.br_taken  = 1;
        bus.br_target = t;
        bus.stall     = st;
        cyc();
    endtask

    initial begin
        clr_in();
        model_reset();
        #1;
        compare();
        @(posedge clk);
        #1;
        rst_n = 1;

        // program load with a final beat alongside ld_done
        bus.ld_req = 1;
        cyc();
        beat(0, 32'h0109_5820, 0);
        beat(1, 32'hAC0B_0000, 0);
        beat(2, 32'h0169_6022, 1);
        clr_in();
        cyc();

        // start with ld_req in the same cycle: loader wins
        bus.start = 1;
        bus.ld_req = 1;
        cyc();
        clr_in();
        bus.ld_done = 1;
        cyc();

        // free run, stall, redirect-with-stall, misaligned redirect
        clr_in();
        bus.start = 1;
        cyc();
        clr_in();
        repeat (2) cyc();
        bus.stall = 1;
        repeat (2) cyc();
        clr_in();
        cyc();
        br(32'h4, 1);
        clr_in();
        repeat (2) cyc();
        br(32'h6, 0);
        clr_in();
        cyc();
        chk("misalign_set", bus.misalign, 1);

        // wrap of the word address, loader ignored in RUN, then halt
        br(32'hFF8, 0);
        clr_in();
        repeat (2) cyc();
        chk("wrap_addr", bus.imem_addr, 0);
        bus.ld_req = 1;
        repeat (2) cyc();
        bus.halt_req = 1;
        cyc();
        clr_in();
        repeat (2) cyc();
        bus.ld_req = 1;
        cyc();

        // reset mid-load with a write beat pending
        bus.ld_req   = 0;
        bus.ld_valid = 1;
        bus.ld_addr  = 10'd7;
        bus.ld_data  = 32'hDEAD_BEEF;
        do_reset();
        clr_in();
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            clr_in();
            bus.start     = ($urandom_range(0, 99) < 8);
            bus.halt_req  = ($urandom_range(0, 99) < 3);
            bus.stall     = ($urandom_range(0, 99) < 25);
            bus.br_taken  = ($urandom_range(0, 99) < 15);
            bus.br_target = ($urandom_range(0, 3) == 0) ? $urandom()
                          : 32'h0000_0F00 + 4 * $urandom_range(0, 80);
            bus.ld_req    = ($urandom_range(0, 99) < 6);
            bus.ld_valid  = ($urandom_range(0, 99) < 60);
            bus.ld_addr   = AW'($urandom());
            bus.ld_data   = $urandom();
            bus.ld_done   = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 499) == 0) do_reset();
            else cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
